// File: rtl/dsp_a_operand_arbiter_if.sv
// Handshake and slice-drive bundle between the two A-operand requesters and the arbiter.
// The master side is the requester/stall source; the slave side is the arbiter.
interface dsp_a_operand_arbiter_if #(
  parameter int DATA_W = 30
);
  logic              REQ0_VALID;
  logic [DATA_W-1:0] REQ0_A;
  logic              REQ0_READY;
  logic              REQ1_VALID;
  logic [DATA_W-1:0] REQ1_A;
  logic              REQ1_READY;
  logic              HOLD;
  logic              FLUSH;
  logic [DATA_W-1:0] A_OUT;
  logic              CEA1;
  logic              CEA2;
  logic              RSTA_OUT;
  logic              OUT_VALID;
  logic              OUT_ID;

  modport master (
    output REQ0_VALID, REQ0_A, REQ1_VALID, REQ1_A, HOLD, FLUSH,
    input  REQ0_READY, REQ1_READY, A_OUT, CEA1, CEA2, RSTA_OUT, OUT_VALID, OUT_ID
  );

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ1_VALID, REQ1_A, HOLD, FLUSH,
    output REQ0_READY, REQ1_READY, A_OUT, CEA1, CEA2, RSTA_OUT, OUT_VALID, OUT_ID
  );
endinterface

// File: rtl/dsp_a_operand_arbiter.sv
// Round-robin front end for the DSP dual A-register path: registers the granted operand,
// drives CEA1/CEA2/RSTA and tracks a (valid, id) tag alongside each operand up to XMUX.
module dsp_a_operand_arbiter #(
  parameter int AREG   = 1,
  parameter int DATA_W = 30
) (
  input  logic                     clk,
  input  logic                     RST,
  dsp_a_operand_arbiter_if.slave   bus
);

  logic              ptr_q, ptr_d;
  logic              gnt0, gnt1, open_w, acc0, acc1, acc;
  logic [DATA_W-1:0] a_q, a_d;
  logic              vld_p0_q, vld_p0_d, id_p0_q, id_p0_d;
  logic              vld_p1_q, vld_p1_d, id_p1_q, id_p1_d;
  logic              vld_p2_q, vld_p2_d, id_p2_q, id_p2_d;

  always_comb begin
    gnt0   = bus.REQ0_VALID & (~bus.REQ1_VALID | ~ptr_q);
    gnt1   = bus.REQ1_VALID & (~bus.REQ0_VALID |  ptr_q);
    open_w = ~bus.HOLD & ~bus.FLUSH & ~RST;
    acc0   = gnt0 & open_w;
    acc1   = gnt1 & open_w;
    acc    = acc0 | acc1;

    ptr_d = ptr_q;
    if (acc0)      ptr_d = 1'b1;
    else if (acc1) ptr_d = 1'b0;

    a_d = a_q;
    if (acc0)      a_d = bus.REQ0_A;
    else if (acc1) a_d = bus.REQ1_A;

    vld_p0_d = vld_p0_q;  id_p0_d = id_p0_q;
    vld_p1_d = vld_p1_q;  id_p1_d = id_p1_q;
    vld_p2_d = vld_p2_q;  id_p2_d = id_p2_q;
    // FLUSH wins over HOLD; under HOLD every tag stays put
    if (bus.FLUSH) begin
      vld_p0_d = 1'b0;  id_p0_d = 1'b0;
      vld_p1_d = 1'b0;  id_p1_d = 1'b0;
      vld_p2_d = 1'b0;  id_p2_d = 1'b0;
    end else if (!bus.HOLD) begin
      vld_p0_d = acc;
      id_p0_d  = acc ? acc1 : id_p0_q;
      vld_p1_d = vld_p0_q;
      id_p1_d  = id_p0_q;
      vld_p2_d = (AREG == 2) ? vld_p1_q : vld_p0_q;
      id_p2_d  = (AREG == 2) ? id_p1_q  : id_p0_q;
    end
  end

  // ---- stage p0: operand register and tag; p1/p2 mirror the slice A1/A2 registers ----
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_q    <= 1'b0;
      a_q      <= '0;
      vld_p0_q <= 1'b0;  id_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;  id_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;  id_p2_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      vld_p0_q <= vld_p0_d;  id_p0_q <= id_p0_d;
      vld_p1_q <= vld_p1_d;  id_p1_q <= id_p1_d;
      vld_p2_q <= vld_p2_d;  id_p2_q <= id_p2_d;
    end
  end

  always_comb begin
    bus.REQ0_READY = acc0;
    bus.REQ1_READY = acc1;
    bus.A_OUT      = a_q;
    bus.RSTA_OUT   = RST | bus.FLUSH;
    bus.CEA1       = (AREG == 2) & vld_p0_q & ~bus.HOLD;
    bus.CEA2       = 1'b0;
    bus.OUT_VALID  = vld_p2_q;
    bus.OUT_ID     = id_p2_q;
    if (AREG == 0) begin
      bus.OUT_VALID = vld_p0_q;
      bus.OUT_ID    = id_p0_q;
    end else if (AREG == 1) begin
      bus.CEA2 = vld_p0_q & ~bus.HOLD;
    end else begin
      bus.CEA2 = vld_p1_q & ~bus.HOLD;
    end
  end

endmodule

// File: tb/tb_dsp_a_operand_arbiter.sv
// Drives one stimulus stream into three arbiters (AREG 0/1/2) together with a slice A-path model,
// and compares every cycle against an operand-age reference model.
module tb_dsp_a_operand_arbiter;
  localparam int DW = 30;

  logic          clk = 1'b0;
  logic          rst, v0, v1, hold, flush;
  logic [DW-1:0] a0, a1;

  always #5 clk = ~clk;

  dsp_a_operand_arbiter_if #(.DATA_W(DW)) ifc [3] ();

  logic          rdy0 [3], rdy1 [3], cea1 [3], cea2 [3], rsta [3], ov [3], oid [3];
  logic [DW-1:0] aout [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign ifc[k].REQ0_VALID = v0;
    assign ifc[k].REQ0_A     = a0;
    assign ifc[k].REQ1_VALID = v1;
    assign ifc[k].REQ1_A     = a1;
    assign ifc[k].HOLD       = hold;
    assign ifc[k].FLUSH      = flush;
    assign rdy0[k] = ifc[k].REQ0_READY;
    assign rdy1[k] = ifc[k].REQ1_READY;
    assign cea1[k] = ifc[k].CEA1;
    assign cea2[k] = ifc[k].CEA2;
    assign rsta[k] = ifc[k].RSTA_OUT;
    assign ov[k]   = ifc[k].OUT_VALID;
    assign oid[k]  = ifc[k].OUT_ID;
    assign aout[k] = ifc[k].A_OUT;
    dsp_a_operand_arbiter #(.AREG(k), .DATA_W(DW)) u_dut (
      .clk (clk),
      .RST (rst),
      .bus (ifc[k])
    );
  end

  typedef struct packed {
    logic          id;
    logic [DW-1:0] d;
    logic [3:0]    age;
  } ent_t;

  ent_t          ent [3][8];
  int            cnt [3];
  logic          ptr_m;
  logic [DW-1:0] a_m;
  logic [DW-1:0] sa1 [3], sa2 [3];
  int            ntests = 0;
  int            nfail  = 0;

  function automatic void chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s areg=%0d got=%h want=%h", tag, k, obs, exp);
    end
  endfunction

  task automatic step(input logic iv0, input logic [DW-1:0] ia0, input logic iv1,
                      input logic [DW-1:0] ia1, input logic ih, input logic iflush, input logic ir);
    logic g0, g1, op, e_ov, e_id, any1, anyk, c1 [3], c2 [3], rs [3];
    logic [DW-1:0] e_d, ao [3];
    int n;
    ent_t tmp [8];
    v0 = iv0; a0 = ia0; v1 = iv1; a1 = ia1; hold = ih; flush = iflush; rst = ir;
    #1;
    g0 = v0 & (!v1 | !ptr_m);
    g1 = v1 & (!v0 |  ptr_m);
    op = !ih && !iflush && !ir;
    for (int k = 0; k < 3; k++) begin
      e_ov = 1'b0; e_id = 1'b0; e_d = '0; any1 = 1'b0; anyk = 1'b0;
      for (int i = 0; i < cnt[k]; i++) begin
        if (int'(ent[k][i].age) == k + 1) begin
          e_ov = 1'b1; e_id = ent[k][i].id; e_d = ent[k][i].d;
        end
        if (ent[k][i].age == 4'd1) any1 = 1'b1;
        if (int'(ent[k][i].age) == k) anyk = 1'b1;
      end
      chk("ready0", k, 32'(rdy0[k]), 32'(g0 & op));
      chk("ready1", k, 32'(rdy1[k]), 32'(g1 & op));
      chk("rsta", k, 32'(rsta[k]), 32'(ir | iflush));
      chk("a_out", k, 32'(aout[k]), 32'(a_m));
      chk("out_valid", k, 32'(ov[k]), 32'(e_ov));
      chk("cea1", k, 32'(cea1[k]), 32'((k == 2) & any1 & !ih));
      chk("cea2", k, 32'(cea2[k]), 32'((k != 0) & anyk & !ih));
      if (e_ov) begin
        chk("out_id", k, 32'(oid[k]), 32'(e_id));
        chk("xmux", k, 32'((k == 0) ? aout[k] : sa2[k]), 32'(e_d));
      end
      c1[k] = cea1[k]; c2[k] = cea2[k]; rs[k] = rsta[k]; ao[k] = aout[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rs[k]) begin
        sa1[k] = '0; sa2[k] = '0;
      end else begin
        if (c2[k]) sa2[k] = (k == 2) ? sa1[k] : ao[k];
        if (c1[k]) sa1[k] = ao[k];
      end
      if (ir || iflush) begin
        cnt[k] = 0;
      end else begin
        if (!ih) begin
          n = 0;
          for (int i = 0; i < cnt[k]; i++) begin
            tmp[n] = ent[k][i];
            tmp[n].age = ent[k][i].age + 4'd1;
            if (int'(tmp[n].age) <= k + 1) n++;
          end
          for (int i = 0; i < n; i++) ent[k][i] = tmp[i];
          cnt[k] = n;
        end
        if (g0 & op) begin
          ent[k][cnt[k]] = '{id: 1'b0, d: ia0, age: 4'd1}; cnt[k]++;
        end else if (g1 & op) begin
          ent[k][cnt[k]] = '{id: 1'b1, d: ia1, age: 4'd1}; cnt[k]++;
        end
      end
    end
    if (ir) begin
      ptr_m = 1'b0; a_m = '0;
    end else if (g0 & op) begin
      ptr_m = 1'b1; a_m = ia0;
    end else if (g1 & op) begin
      ptr_m = 1'b0; a_m = ia1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; sa1[k] = '0; sa2[k] = '0;
    end
    ptr_m = 1'b0; a_m = '0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; hold = 1'b0; flush = 1'b0; rst = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 30'h155, 1'b1, 30'h2AA, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) chk("rst_out_id", k, 32'(oid[k]), 32'd0);
    idle(1);

    // single REQ0 operand
    step(1'b1, 30'h11, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // both requesters valid for 4 cycles
    for (int i = 0; i < 4; i++)
      step(1'b1, 30'h100 + 30'(i), 1'b1, 30'h200 + 30'(i), 1'b0, 1'b0, 1'b0);
    idle(4);

    // stream of 3 with a 2-cycle HOLD in the middle
    step(1'b1, 30'hA1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 30'hA2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 30'hA3, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 30'hA3, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 30'hA3, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // FLUSH with two operands in flight, then a fresh accept
    step(1'b0, '0, 1'b1, 30'hB1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 30'hB2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 30'hB3, 1'b1, 30'hB4, 1'b1, 1'b1, 1'b0);
    step(1'b1, 30'hC1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // REQ1 all-ones operand
    step(1'b0, '0, 1'b1, 30'h3FFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(3);

    // RST with an operand in S1, then both valid after reset
    step(1'b0, '0, 1'b1, 30'hD1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b1, 30'hE0, 1'b1, 30'hE1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 30'hE2, 1'b1, 30'hE3, 1'b0, 1'b0, 1'b0);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) < 6, 30'($urandom), $urandom_range(0, 9) < 6, 30'($urandom),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dsp_a_operand_arbiter.md
# dsp_a_operand_arbiter

Two-requester front end for the DSP slice dual A-register path. It accepts 30-bit A operands from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. It drives the slice's A data input, CEA1/CEA2 clock enables and RSTA, and tracks each operand through the AREG pipeline so downstream logic knows when XMUX holds valid data and which requester it belongs to. It sits directly in front of the dual A-register instance; its AREG must match that instance's AREG.

## Interface
- AREG, 1: A-register depth of the driven slice path (0, 1 or 2); sets CE pattern and latency.
- clk  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has an operand.
- REQ0_A  in  30  requester 0 operand.
- REQ0_READY  out  1  requester 0 operand accepted this cycle (when VALID also high).
- REQ1_VALID, REQ1_A, REQ1_READY: same for requester 1.
- HOLD  in  1  downstream stall; freezes the A pipeline.
- FLUSH  in  1  discard all in-flight operands.
- A_OUT  out  30  registered operand to slice A input.
- CEA1  out  1  to slice CEA1.
- CEA2  out  1  to slice CEA2.
- RSTA_OUT  out  1  to slice RSTA.
- OUT_VALID  out  1  slice XMUX holds an accepted operand this cycle.
- OUT_ID  out  1  requester index of the operand on XMUX; valid only with OUT_VALID.

## Operation
- Arbitration:
  - Round-robin pointer PTR is a register, reset to 0.
  - When both VALIDs are high, grant goes to requester PTR.
  - When only one is high, grant goes to that one.
  - On an accept by requester i, PTR becomes ~i.
- REQi_READY = grant_i & ~HOLD & ~FLUSH & ~RST. It is combinational and may depend on the other requester's VALID.
- Accept: the operand is registered into A_OUT. Stage tag S0 (valid, id) is set.
  - A_OUT holds its value until the next accept.
- AREG=2:
  - CEA1 = S0.valid & ~HOLD. S0 advances to S1.
  - CEA2 = S1.valid & ~HOLD. S1 advances to S2.
  - OUT_VALID/OUT_ID = S2.
- AREG=1:
  - CEA1 = 0.
  - CEA2 = S0.valid & ~HOLD. S0 advances to S2.
  - OUT_VALID/OUT_ID = S2.
- AREG=0:
  - CEA1 = CEA2 = 0.
  - OUT_VALID/OUT_ID = S0. XMUX is combinational from A_OUT.
- A tag stage clears when its content advances and no new content enters.
- CEs are asserted only for valid stages. Bubbles leave slice registers untouched, with OUT_VALID low.
- HOLD:
  - All CEs are 0, all tags frozen, both READYs low.
  - OUT_VALID stays as-is, so the same operand is reported every held cycle.
- FLUSH:
  - All tags are cleared at the next edge.
  - RSTA_OUT = 1 that cycle, which clears slice A1/A2.
  - FLUSH overrides HOLD and pending requests. PTR is unchanged.
- RSTA_OUT = RST | FLUSH (combinational).
- RST: all tags, A_OUT and PTR are cleared at the next edge. RST mid-operation drops in-flight operands with no OUT_VALID for them.

## Timing
- Reset values (cycle after RST edge): A_OUT=0, CEA1=0, CEA2=0, OUT_VALID=0, OUT_ID=0, PTR=0. RSTA_OUT=1 while RST is high.
- Accept at cycle t gives A_OUT valid at t+1. OUT_VALID rises at:
  - t+1 for AREG=0;
  - t+2 for AREG=1;
  - t+3 for AREG=2.
- Each HOLD cycle adds exactly one cycle to the latency of every in-flight operand.
- Throughput: one accept per cycle with no HOLD. Back-to-back operands appear on consecutive OUT_VALID cycles in accept order.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1… starting with 0 after reset.

## Test plan
- AREG=2, REQ0 sends 0x0000_0011 at t, REQ1 idle:
  - REQ0_READY=1 at t.
  - CEA1=1 at t+1, CEA2=1 at t+2.
  - OUT_VALID=1, OUT_ID=0 at t+3, with slice XMUX=0x11.
- AREG=1, both requesters hold VALID for 4 cycles with distinct operands:
  - accepts alternate 0,1,0,1;
  - OUT_VALID high on 4 consecutive cycles starting t+2, OUT_ID sequence 0,1,0,1;
  - CEA1 never asserted.
- AREG=2, stream of 3 operands, HOLD high for 2 cycles mid-stream:
  - READY and CEs low during HOLD;
  - no operand lost or duplicated;
  - final OUT_VALID 2 cycles later than the unstalled run.
- AREG=2, FLUSH asserted with 2 operands in flight:
  - RSTA_OUT=1 that cycle, READY=0;
  - no OUT_VALID for flushed operands;
  - a new accept after FLUSH emerges normally at +3.
- AREG=0, REQ1 sends 0x3FFF_FFFF: OUT_VALID=1, OUT_ID=1 the cycle after accept; CEA1=CEA2=0 throughout.
- RST asserted with an operand in S1 (AREG=2): the operand never appears, all outputs reach reset values, and the first post-reset grant with both valid goes to REQ0.
